// File: rtl/serial_frame_receiver_if.sv
// Serial bit stream in, parallel framed word out, plus a status flag.
// The master drives the line and the strobe; the slave returns the word, its error flags and busy.
interface serial_frame_receiver_if #(
  parameter int N = 4
);
  logic         in;
  logic         en;
  logic [N-1:0] data_out;
  logic         valid;
  logic         par_err;
  logic         frame_err;
  logic         busy;

  modport master (
    output in, en,
    input  data_out, valid, par_err, frame_err, busy
  );

  modport slave (
    input  in, en,
    output data_out, valid, par_err, frame_err, busy
  );
endinterface

// File: rtl/serial_frame_receiver.sv
// Deframes start/N data (LSB first)/optional parity/stop from a strobed serial line into a word.
// valid pulses for one cycle after the stop-bit edge; there is no backpressure, and en paces the bits.
module serial_frame_receiver #(
  parameter int N          = 4,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                    clk,
  input  logic                    clear_n,
  serial_frame_receiver_if.slave  bus
);
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  sh;
  logic [N-1:0]  sh_nxt;
  logic          par_bit;
  logic          par_exp;

  // Right shift with the new bit entering at the MSB, so d[0] settles at bit 0.
  always_comb begin
    sh_nxt        = sh;
    sh_nxt[N-1]   = bus.in;
    for (int i = 0; i < N - 1; i++) begin
      sh_nxt[i] = sh[i+1];
    end
  end

  assign par_exp  = (^sh) ^ (PARITY_ODD != 0);
  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state         <= IDLE;
      cnt           <= '0;
      sh            <= '0;
      par_bit       <= 1'b0;
      bus.data_out  <= '0;
      bus.valid     <= 1'b0;
      bus.par_err   <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      if (bus.en) begin
        case (state)
          IDLE: begin
            if (bus.in) begin
              state <= DATA;
              cnt   <= '0;
            end
          end
          DATA: begin
            sh  <= sh_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(N - 1)) begin
              state <= (PARITY_EN != 0) ? PARITY : STOP;
            end
          end
          PARITY: begin
            par_bit <= bus.in;
            state   <= STOP;
          end
          STOP: begin
            // Errored frames are still delivered; the flags carry the verdict.
            bus.data_out  <= sh;
            bus.valid     <= 1'b1;
            bus.par_err   <= (PARITY_EN != 0) ? (par_bit != par_exp) : 1'b0;
            bus.frame_err <= bus.in;
            state         <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed plus randomized frames, checked against a frame-level model (expected word and flags per frame).
module tb_serial_frame_receiver;
  localparam int N  = 4;
  localparam int PE = 1;
  localparam int PO = 0;

  logic clk     = 1'b0;
  logic clear_n = 1'b0;

  serial_frame_receiver_if #(.N(N)) bus ();

  serial_frame_receiver #(.N(N), .PARITY_EN(PE), .PARITY_ODD(PO)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] d;
    logic         pe;
    logic         fe;
    int           t;
  } rec_t;

  rec_t exp_q[$];
  rec_t got_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  logic prev_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Observer: records every delivered frame and checks that valid never lasts two cycles.
  always @(negedge clk) begin
    cyc++;
    if (bus.busy) busy_cnt++;
    if (bus.valid) begin
      chk("valid_width", 32'(prev_valid), 32'd0);
      got_q.push_back('{d: bus.data_out, pe: bus.par_err, fe: bus.frame_err, t: cyc});
    end
    prev_valid = bus.valid;
  end

  // gap strobe-less cycles with a noisy line precede each sampled bit.
  task automatic send_bit(input logic b, input int gap);
    repeat (gap) begin
      @(negedge clk);
      bus.en = 1'b0;
      bus.in = 1'($urandom);
    end
    @(negedge clk);
    bus.en = 1'b1;
    bus.in = b;
  endtask

  task automatic send_frame(input logic [N-1:0] d, input logic pbit, input logic stop, input int gap);
    logic exp_pe;
    exp_pe = (PE != 0) ? (pbit != ((^d) ^ (PO != 0))) : 1'b0;
    exp_q.push_back('{d: d, pe: exp_pe, fe: stop, t: 0});
    send_bit(1'b1, gap);
    for (int i = 0; i < N; i++) send_bit(d[i], gap);
    if (PE != 0) send_bit(pbit, gap);
    send_bit(stop, gap);
  endtask

  task automatic drain(input string tag);
    rec_t e;
    rec_t g;
    @(negedge clk);
    bus.in = 1'b0;
    bus.en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk({tag, "_data"}, 32'(g.d), 32'(e.d));
      chk({tag, "_par"},  32'(g.pe), 32'(e.pe));
      chk({tag, "_frm"},  32'(g.fe), 32'(e.fe));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    logic [N-1:0] rd;
    logic         rp;
    logic         rs;

    bus.in = 1'b0;
    bus.en = 1'b0;
    #12;
    chk("rst_data",  32'(bus.data_out), 32'd0);
    chk("rst_valid", 32'(bus.valid),    32'd0);
    chk("rst_busy",  32'(bus.busy),     32'd0);
    chk("rst_err",   32'({bus.par_err, bus.frame_err}), 32'd0);
    @(negedge clk);
    clear_n = 1'b1;
    bus.en  = 1'b1;

    // 1: A with good parity, valid right after the stop edge, busy for 6 cycles.
    @(negedge clk);
    #1 busy_cnt = 0;
    send_frame(4'hA, 1'b0, 1'b0, 0);
    @(negedge clk);
    #1;
    chk("t1_valid", 32'(bus.valid), 32'd1);
    chk("t1_data",  32'(bus.data_out), 32'hA);
    bus.in = 1'b0;
    @(negedge clk);
    #1;
    chk("t1_valid_drop", 32'(bus.valid), 32'd0);
    chk("t1_busy_cycles", 32'(busy_cnt), 32'd6);
    drain("t1");

    // 2: bad parity, then F.
    send_frame(4'hA, 1'b1, 1'b0, 0);
    drain("t2a");
    send_frame(4'hF, 1'b0, 1'b0, 0);
    drain("t2b");

    // 3: stop bit 1 is flagged and not taken as a new start.
    send_frame(4'h1, 1'b1, 1'b1, 0);
    drain("t3");
    chk("t3_idle", 32'(bus.busy), 32'd0);

    // 4: en every third cycle; a high line without a strobe is ignored.
    repeat (3) begin
      @(negedge clk);
      bus.en = 1'b0;
      bus.in = 1'b1;
    end
    @(negedge clk);
    #1;
    chk("t4_no_strobe", 32'(bus.busy), 32'd0);
    bus.in = 1'b0;
    send_frame(4'h6, 1'b0, 1'b0, 2);
    drain("t4");

    // 5: back-to-back 3 then C.
    send_frame(4'h3, 1'b0, 1'b0, 0);
    send_frame(4'hC, 1'b0, 1'b0, 0);
    @(negedge clk);
    bus.in = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("t5_pulses", got_q.size(), 32'd2);
    if (got_q.size() >= 2) chk("t5_spacing", 32'(got_q[1].t - got_q[0].t), 32'd7);
    drain("t5");

    // 6: asynchronous clear after two data bits, then a clean 9.
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    @(posedge clk);
    #2 clear_n = 1'b0;
    #1;
    chk("t6_data",  32'(bus.data_out), 32'd0);
    chk("t6_busy",  32'(bus.busy), 32'd0);
    chk("t6_flags", 32'({bus.valid, bus.par_err, bus.frame_err}), 32'd0);
    @(negedge clk);
    bus.in  = 1'b0;
    clear_n = 1'b1;
    send_frame(4'h9, 1'b0, 1'b0, 0);
    drain("t6");

    // Randomized frames: random data, occasional bad parity/stop, random strobe gaps and idle strobes.
    for (int f = 0; f < 40; f++) begin
      rd = N'($urandom);
      rp = ((^rd) ^ (PO != 0)) ^ ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 4) == 0);
      send_frame(rd, rp, rs, $urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) send_bit(1'b0, $urandom_range(0, 1));
    end
    drain("rnd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
